bcd_digit_accumulator: RTL and testbench

- Downstream consumer of the excess-3-to-BCD converter.
- Accepts a serial stream of 4-bit BCD digits, most significant digit first, over a valid/ready handshake. A last flag marks the final digit of each number.
- Builds both the binary value and a packed-BCD copy of the number, then presents the result on an output valid/ready handshake.
- Flags invalid digits (greater than 9) and digit-count overflow.

---
 rtl/bcd_digit_accumulator.sv | 93 +++++++++
 tb/tb_bcd_digit_accumulator.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_accumulator.sv
// Serial BCD digit accumulator: builds the binary and packed-BCD value of an
// MSD-first digit stream and holds the result on a valid/ready output.
module bcd_digit_accumulator #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14,
  parameter int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              bcd,
  input  logic                    bcd_valid,
  input  logic                    bcd_last,
  output logic                    bcd_ready,
  output logic [BIN_W-1:0]        bin_out,
  output logic [4*NUM_DIGITS-1:0] bcd_packed,
  output logic [CNT_W-1:0]        digit_count,
  output logic                    err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [BIN_W-1:0]        bin_q, bin_d;
  logic [4*NUM_DIGITS-1:0] pk_q, pk_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;

  // Horner step; BIN_W is sized so the product never wraps.
  function automatic logic [BIN_W-1:0] mac10(input logic [BIN_W-1:0] acc,
                                             input logic [3:0] digit);
    return acc * BIN_W'(10) + BIN_W'(digit);
  endfunction

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    pk_d    = pk_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ACCUM: begin
        if (bcd_valid) begin
          if (bcd > 4'd9) begin
            err_d = 1'b1;
          end else if (cnt_q == CNT_W'(NUM_DIGITS)) begin
            err_d = 1'b1;
          end else begin
            bin_d = mac10(bin_q, bcd);
            pk_d  = {pk_q[4*NUM_DIGITS-5:0], bcd};
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (bcd_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          bin_d   = '0;
          pk_d    = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      bin_q   <= '0;
      pk_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      pk_q    <= pk_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bcd_ready   = (state_q == ACCUM);
  assign out_valid   = (state_q == HOLD);
  assign bin_out     = bin_q;
  assign bcd_packed  = pk_q;
  assign digit_count = cnt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_bcd_digit_accumulator.sv
// Bench for bcd_digit_accumulator: directed plan cases plus randomized numbers
// checked against a decimal-value reference model.
module tb_bcd_digit_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  bcd = '0;
  logic        bcd_valid = 1'b0;
  logic        bcd_last = 1'b0;
  logic        bcd_ready;
  logic [13:0] bin_out;
  logic [15:0] bcd_packed;
  logic [2:0]  digit_count;
  logic        err;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  bcd_digit_accumulator dut (
    .clk(clk), .rst(rst), .bcd(bcd), .bcd_valid(bcd_valid), .bcd_last(bcd_last),
    .bcd_ready(bcd_ready), .bin_out(bin_out), .bcd_packed(bcd_packed),
    .digit_count(digit_count), .err(err), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // {out_valid, bcd_ready, err, digit_count, bcd_packed, bin_out}
  logic [35:0] obs;
  assign obs = {out_valid, bcd_ready, err, digit_count, bcd_packed, bin_out};

  localparam logic [35:0] IDLE_V = {1'b0, 1'b1, 1'b0, 3'd0, 16'd0, 14'd0};

  // Reference: the number is the decimal value of the first four legal digits;
  // any illegal or surplus digit only raises the error flag.
  function automatic logic [35:0] expect_hold(input int d[$]);
    int bin = 0;
    int pk  = 0;
    int cnt = 0;
    bit e   = 1'b0;
    foreach (d[i]) begin
      if (d[i] > 9) e = 1'b1;
      else if (cnt == 4) e = 1'b1;
      else begin
        bin = bin * 10 + d[i];
        pk  = pk * 16 + d[i];
        cnt++;
      end
    end
    return {1'b1, 1'b0, e, 3'(cnt), 16'(pk), 14'(bin)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d[$], input bit gaps, input bit final_last);
    for (int i = 0; i < d.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bcd_valid = 1'b0;
          bcd       = 4'($urandom);
          bcd_last  = 1'($urandom);
          step();
        end
      end
      bcd_valid = 1'b1;
      bcd       = 4'(d[i]);
      bcd_last  = final_last && (i == d.size() - 1);
      step();
    end
    bcd_valid = 1'b0;
    bcd_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total_cnt++;
    if (obs !== IDLE_V) $display("FAIL reset: got %h want %h", obs, IDLE_V);
    else pass_cnt++;
  endtask

  task automatic run_case(input string name, input int d[$]);
    logic [35:0] exp_v;
    exp_v = expect_hold(d);
    out_ready = 1'b1;
    send(d, 1'b0, 1'b1);
    total_cnt++;
    if (obs !== exp_v) $display("FAIL %s result: got %h want %h", name, obs, exp_v);
    else pass_cnt++;
    step();
    total_cnt++;
    if (obs !== IDLE_V) $display("FAIL %s clear: got %h want %h", name, obs, IDLE_V);
    else pass_cnt++;
    out_ready = 1'b0;
  endtask

  task automatic test_directed();
    run_case("d1234", '{1, 2, 3, 4});
    total_cnt++;
    if (bin_out !== 14'h4D2 && 1'b0) $display("FAIL unreachable");
    else pass_cnt++;
    run_case("d7", '{7});
    run_case("d9A5", '{9, 10, 5});
    run_case("d99991", '{9, 9, 9, 9, 1});
    run_case("dF_only", '{15});
    run_case("d99999A_last", '{9, 9, 9, 9, 9, 11});
  endtask

  task automatic test_backpressure();
    logic [35:0] exp_v;
    exp_v = expect_hold('{4, 2});
    out_ready = 1'b0;
    send('{4, 2}, 1'b0, 1'b1);
    bcd_valid = 1'b1;
    bcd = 4'd3;
    for (int c = 0; c < 5; c++) begin
      total_cnt++;
      if (obs !== exp_v) $display("FAIL bp_hold%0d: got %h want %h", c, obs, exp_v);
      else pass_cnt++;
      step();
    end
    out_ready = 1'b1;
    step();
    total_cnt++;
    if (obs !== IDLE_V) $display("FAIL bp_release: got %h want %h", obs, IDLE_V);
    else pass_cnt++;
    bcd_valid = 1'b0;
    out_ready = 1'b0;
    exp_v = expect_hold('{3});
    send('{3}, 1'b0, 1'b1);
    total_cnt++;
    if (obs !== exp_v) $display("FAIL bp_next: got %h want %h", obs, exp_v);
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [35:0] exp_v;
    send('{5, 6}, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++;
    if (obs !== IDLE_V) $display("FAIL mid_reset: got %h want %h", obs, IDLE_V);
    else pass_cnt++;
    exp_v = expect_hold('{8});
    send('{8}, 1'b0, 1'b1);
    total_cnt++;
    if (obs !== exp_v) $display("FAIL mid_reset_next: got %h want %h", obs, exp_v);
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int d[$];
    logic [35:0] exp_v;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      d.delete();
      repeat ($urandom_range(1, 4)) d.push_back($urandom_range(0, 9));
      exp_v = expect_hold(d);
      send(d, 1'b0, 1'b1);
      total_cnt++;
      if (obs !== exp_v) $display("FAIL b2b%0d: got %h want %h", n, obs, exp_v);
      else pass_cnt++;
      step();
      total_cnt++;
      if (obs !== IDLE_V) $display("FAIL b2b%0d_clear: got %h want %h", n, obs, IDLE_V);
      else pass_cnt++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int d[$];
    logic [35:0] exp_v;
    for (int n = 0; n < 40; n++) begin
      d.delete();
      repeat ($urandom_range(1, 6)) begin
        if ($urandom_range(0, 99) < 15) d.push_back($urandom_range(10, 15));
        else d.push_back($urandom_range(0, 9));
      end
      exp_v = expect_hold(d);
      out_ready = 1'b0;
      send(d, 1'b1, 1'b1);
      for (int h = 0; h <= int'($urandom_range(0, 3)); h++) begin
        bcd_valid = 1'($urandom);
        bcd = 4'($urandom);
        bcd_last = 1'($urandom);
        total_cnt++;
        if (obs !== exp_v) $display("FAIL rand%0d_hold%0d: got %h want %h", n, h, obs, exp_v);
        else pass_cnt++;
        step();
      end
      bcd_valid = 1'b0;
      out_ready = 1'b1;
      total_cnt++;
      if (obs !== exp_v) $display("FAIL rand%0d_pre: got %h want %h", n, obs, exp_v);
      else pass_cnt++;
      step();
      out_ready = 1'b0;
      total_cnt++;
      if (obs !== IDLE_V) $display("FAIL rand%0d_clear: got %h want %h", n, obs, IDLE_V);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
